// File: rtl/gonso_pkg.sv
// Shared constants for the gonso multi-channel register bank: register
// offsets, CTRL/STATUS bit positions, channel window layout and the
// byte-enable helpers used by every bus-writable register.
package gonso_pkg;

    localparam logic [11:0] OFF_CTRL    = 12'h000;
    localparam logic [11:0] OFF_STATUS  = 12'h004;
    localparam logic [11:0] OFF_DONE    = 12'h008;
    localparam logic [11:0] OFF_MASK    = 12'h00C;
    localparam logic [11:0] OFF_STEP    = 12'h010;
    localparam logic [11:0] OFF_CH_BASE = 12'h100;

    // Each channel owns an IN word followed by a RES word
    localparam int CH_STRIDE  = 8;
    localparam int CH_RES_OFS = 4;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_BIT    = 1;
    localparam int STATUS_INFL_LSB = 16;
    localparam int STATUS_OVF_BIT  = 31;

    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = sel_to_mask(sel);
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/gonso_multi_regbank_if.sv
// Wishbone slave bus bundle for the gonso register bank.
interface gonso_multi_regbank_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_we_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o
    );

endinterface

// File: rtl/gonso_pipe.sv
// Non-stalling LAT-stage compute pipeline: adds input + step at the entry
// and shifts {valid, tag, data} through LAT registered stages.
// GONSO_SATURATE_EN: sum clamps at all-ones and in_ovf_o flags a clamp.
module gonso_pipe #(
    parameter int LAT = 2,
    parameter int DW  = 32,
    parameter int TW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [TW-1:0]     in_tag_i,
    input  logic [DW-1:0]     in_a_i,
    input  logic [DW-1:0]     in_b_i,
`ifdef GONSO_SATURATE_EN
    output logic              in_ovf_o,
`endif
    output logic [LAT-1:0]    stage_valid_o,
    output logic [LAT*TW-1:0] stage_tag_o,
    output logic              wb_valid_o,
    output logic [TW-1:0]     wb_tag_o,
    output logic [DW-1:0]     wb_data_o
);

    logic [LAT-1:0] v_q;
    logic [TW-1:0]  tag_q  [LAT];
    logic [DW-1:0]  data_q [LAT];
    logic [DW-1:0]  sum_s;

`ifdef GONSO_SATURATE_EN
    logic [DW:0] wide_s;

    // Saturating entry adder
    always_comb begin
        wide_s   = {1'b0, in_a_i} + {1'b0, in_b_i};
        in_ovf_o = in_valid_i & wide_s[DW];
        if (wide_s[DW]) begin
            sum_s = '1;
        end else begin
            sum_s = wide_s[DW-1:0];
        end
    end
`else
    // Wrapping entry adder (modulo 2^DW)
    always_comb begin
        sum_s = in_a_i + in_b_i;
    end
`endif

    // Shift valid/tag/data one stage per cycle; the pipe never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                v_q[i]    <= 1'b0;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            v_q[0]    <= in_valid_i;
            tag_q[0]  <= in_tag_i;
            data_q[0] <= sum_s;
            for (int i = 1; i < LAT; i++) begin
                v_q[i]    <= v_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Flatten stage tags for the in-flight status view
    always_comb begin
        stage_tag_o = '0;
        for (int i = 0; i < LAT; i++) begin
            stage_tag_o[i*TW +: TW] = tag_q[i];
        end
    end

    assign stage_valid_o = v_q;
    assign wb_valid_o    = v_q[LAT-1];
    assign wb_tag_o      = tag_q[LAT-1];
    assign wb_data_o     = data_q[LAT-1];

endmodule

// File: rtl/gonso_multi_regbank.sv
// Wishbone register bank with NCH compute channels sharing one LAT-stage
// pipeline. Writing IN[c] queues a job; a round-robin arbiter issues at most
// one job per cycle; the result lands in RES[c] and sets sticky DONE[c].
// GONSO_SATURATE_EN: saturating add and sticky overflow flag in STATUS[31].
module gonso_multi_regbank
    import gonso_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          DW        = 32,
    parameter int          LAT       = 2,
    parameter logic [31:0] BASE_ADDR = 32'h3003_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gonso_multi_regbank_if.slave  wbs,
    output logic                  irq,
    output logic                  busy
);

    localparam int TW = (NCH > 1) ? $clog2(NCH) : 1;

    logic            access_s, hit_s, wr_s, rd_s;
    logic [11:0]     off_s;
    logic            dec_ctrl_s, dec_status_s, dec_done_s, dec_mask_s, dec_step_s;
    logic            dec_in_s, dec_res_s;
    logic [TW-1:0]   ch_s;

    logic            ack_q;
    logic [31:0]     rdat_q, rdat_d, status_s;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [NCH-1:0]  mask_q, mask_d, pend_q, pend_d, done_q, done_d;
    logic [NCH-1:0]  pend_set_s, pend_clr_s, done_clr_s, wb_set_s, infl_s;
    logic [DW-1:0]   step_q, step_d;
    logic [DW-1:0]   in_q [NCH];
    logic [DW-1:0]   in_d [NCH];
    logic [DW-1:0]   res_q [NCH];
    logic            irq_q;
    logic [TW-1:0]   last_q, grant_s;
    logic            found_s, issue_s;

    logic [LAT-1:0]    stage_v_s;
    logic [LAT*TW-1:0] stage_tag_s;
    logic              wb_valid_s;
    logic [TW-1:0]     wb_tag_s;
    logic [DW-1:0]     wb_data_s;

`ifdef GONSO_SATURATE_EN
    logic ovf_q, ovf_d, ovf_clr_s, in_ovf_s;
`endif

    // Bus qualification and address decode
    always_comb begin
        int ch_off;
        access_s     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
        wr_s         = access_s & wbs.wbs_we_i;
        rd_s         = access_s & ~wbs.wbs_we_i;
        hit_s        = (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]) && (wbs.wbs_adr_i[1:0] == 2'b00);
        off_s        = wbs.wbs_adr_i[11:0];
        dec_ctrl_s   = hit_s && (off_s == OFF_CTRL);
        dec_status_s = hit_s && (off_s == OFF_STATUS);
        dec_done_s   = hit_s && (off_s == OFF_DONE);
        dec_mask_s   = hit_s && (off_s == OFF_MASK);
        dec_step_s   = hit_s && (off_s == OFF_STEP);
        ch_off       = int'(off_s) - int'(OFF_CH_BASE);
        if (hit_s && (ch_off >= 0) && (ch_off < NCH * CH_STRIDE)) begin
            ch_s      = TW'(ch_off / CH_STRIDE);
            dec_in_s  = (ch_off % CH_STRIDE) == 0;
            dec_res_s = (ch_off % CH_STRIDE) == CH_RES_OFS;
        end else begin
            ch_s      = '0;
            dec_in_s  = 1'b0;
            dec_res_s = 1'b0;
        end
    end

    // Software writes: byte-enabled register updates, job queueing, W1C requests
    always_comb begin
        ctrl_d     = ctrl_q;
        mask_d     = mask_q;
        step_d     = step_q;
        in_d       = in_q;
        pend_set_s = '0;
        done_clr_s = '0;
`ifdef GONSO_SATURATE_EN
        ovf_clr_s  = 1'b0;
`endif
        if (wr_s) begin
            if (dec_ctrl_s) begin
                if (wbs.wbs_sel_i[0]) begin
                    ctrl_d = wbs.wbs_dat_i[1:0];
                end else begin
                    ctrl_d = ctrl_q;
                end
            end else if (dec_done_s) begin
                done_clr_s = NCH'(wbs.wbs_dat_i & sel_to_mask(wbs.wbs_sel_i));
            end else if (dec_mask_s) begin
                mask_d = NCH'(byte_merge(32'(mask_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
            end else if (dec_step_s) begin
                step_d = DW'(byte_merge(32'(step_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
            end else if (dec_in_s) begin
                in_d[ch_s]       = DW'(byte_merge(32'(in_q[ch_s]), wbs.wbs_dat_i, wbs.wbs_sel_i));
                pend_set_s[ch_s] = |wbs.wbs_sel_i;
`ifdef GONSO_SATURATE_EN
            end else if (dec_status_s) begin
                ovf_clr_s = wbs.wbs_sel_i[3] & wbs.wbs_dat_i[STATUS_OVF_BIT];
`endif
            end else begin
                ctrl_d = ctrl_q;
            end
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Round-robin pick of the first pending channel after the last grant
    always_comb begin
        int            idx;
        logic [TW-1:0] cand;
        found_s = 1'b0;
        grant_s = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx  = (int'(last_q) + i) % NCH;
            cand = TW'(idx);
            if (!found_s && pend_q[cand]) begin
                found_s = 1'b1;
                grant_s = cand;
            end else begin
            end
        end
        issue_s = ctrl_q[CTRL_EN_BIT] & found_s;
    end

    // Pending/done next state; a same-cycle set always beats a clear
    always_comb begin
        pend_clr_s = '0;
        wb_set_s   = '0;
        if (issue_s) begin
            pend_clr_s[grant_s] = 1'b1;
        end else begin
            pend_clr_s = '0;
        end
        if (wb_valid_s) begin
            wb_set_s[wb_tag_s] = 1'b1;
        end else begin
            wb_set_s = '0;
        end
        pend_d = (pend_q & ~pend_clr_s) | pend_set_s;
        done_d = (done_q & ~done_clr_s) | wb_set_s;
`ifdef GONSO_SATURATE_EN
        ovf_d  = (ovf_q & ~ovf_clr_s) | in_ovf_s;
`endif
    end

    // STATUS assembly and registered read-data mux
    always_comb begin
        infl_s = '0;
        for (int i = 0; i < LAT; i++) begin
            if (stage_v_s[i]) begin
                infl_s[stage_tag_s[i*TW +: TW]] = 1'b1;
            end else begin
            end
        end
        status_s                          = 32'd0;
        status_s[NCH-1:0]                 = pend_q;
        status_s[STATUS_INFL_LSB +: NCH]  = infl_s;
`ifdef GONSO_SATURATE_EN
        status_s[STATUS_OVF_BIT]          = ovf_q;
`else
        status_s[STATUS_OVF_BIT]          = 1'b0;
`endif
        if (rd_s) begin
            if (dec_ctrl_s)        rdat_d = 32'(ctrl_q);
            else if (dec_status_s) rdat_d = status_s;
            else if (dec_done_s)   rdat_d = 32'(done_q);
            else if (dec_mask_s)   rdat_d = 32'(mask_q);
            else if (dec_step_s)   rdat_d = 32'(step_q);
            else if (dec_in_s)     rdat_d = 32'(in_q[ch_s]);
            else if (dec_res_s)    rdat_d = 32'(res_q[ch_s]);
            else                   rdat_d = 32'd0;
        end else begin
            rdat_d = 32'd0;
        end
    end

    gonso_pipe #(.LAT(LAT), .DW(DW), .TW(TW)) u_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (issue_s),
        .in_tag_i      (grant_s),
        .in_a_i        (in_q[grant_s]),
        .in_b_i        (step_q),
`ifdef GONSO_SATURATE_EN
        .in_ovf_o      (in_ovf_s),
`endif
        .stage_valid_o (stage_v_s),
        .stage_tag_o   (stage_tag_s),
        .wb_valid_o    (wb_valid_s),
        .wb_tag_o      (wb_tag_s),
        .wb_data_o     (wb_data_s)
    );

    // Register state, bus response, result writeback and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            rdat_q <= 32'd0;
            ctrl_q <= 2'd0;
            mask_q <= '0;
            step_q <= '0;
            pend_q <= '0;
            done_q <= '0;
            irq_q  <= 1'b0;
            last_q <= TW'(NCH - 1);
`ifdef GONSO_SATURATE_EN
            ovf_q  <= 1'b0;
`endif
            for (int c = 0; c < NCH; c++) begin
                in_q[c]  <= '0;
                res_q[c] <= '0;
            end
        end else begin
            ack_q  <= access_s;
            rdat_q <= rdat_d;
            ctrl_q <= ctrl_d;
            mask_q <= mask_d;
            step_q <= step_d;
            pend_q <= pend_d;
            done_q <= done_d;
            irq_q  <= ctrl_q[CTRL_IRQ_BIT] & (|(done_q & mask_q));
`ifdef GONSO_SATURATE_EN
            ovf_q  <= ovf_d;
`endif
            if (issue_s) begin
                last_q <= grant_s;
            end
            for (int c = 0; c < NCH; c++) begin
                in_q[c] <= in_d[c];
                if (wb_valid_s && (wb_tag_s == TW'(c))) begin
                    res_q[c] <= wb_data_s;
                end
            end
        end
    end

    assign wbs.wbs_dat_o = rdat_q;
    assign wbs.wbs_ack_o = ack_q;
    assign irq           = irq_q;
    assign busy          = (|pend_q) | (|stage_v_s);

endmodule

// File: tb/tb_gonso_multi_regbank.sv
// Directed bench for gonso_multi_regbank. Bus accesses push their expected
// read data into a queue; a monitor pops and compares on every ack.
module tb_gonso_multi_regbank;

    localparam logic [31:0] B = 32'h3003_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq, busy;

    gonso_multi_regbank_if bus();

    gonso_multi_regbank #(.NCH(4), .DW(32), .LAT(2), .BASE_ADDR(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wbs   (bus),
        .irq   (irq),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endfunction

    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit do_chk, input logic [31:0] exp,
                        input string nm);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        exp_q.push_back(exp);
        chk_q.push_back(do_chk);
        name_q.push_back(nm);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) got = 1'b1;
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within 20 cycles, required an ack", nm);
        end
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        xfer(1'b1, adr, dat, sel, 1'b0, 32'd0, "write");
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
        xfer(1'b0, adr, 32'd0, 4'hF, 1'b1, exp, nm);
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack consumes one scoreboard entry
    initial begin
        logic [31:0] e;
        bit          c;
        string       n;
        forever begin
            @(negedge clk);
            if (bus.wbs_ack_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got an ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    c = chk_q.pop_front();
                    n = name_q.pop_front();
                    if (c) check(n, bus.wbs_dat_o, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'd0;
        bus.wbs_dat_i = 32'd0;
        bus.wbs_sel_i = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset defaults
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rd(B + 32'h000, 32'h0, "rst_ctrl");
        rd(B + 32'h004, 32'h0, "rst_status");
        rd(B + 32'h008, 32'h0, "rst_done");
        for (int c = 0; c < 4; c++) rd(B + 32'h104 + 32'(8 * c), 32'h0, "rst_res");

        // Round-robin ordering from a fresh arbiter
        wr(B + 32'h010, 32'd0, 4'hF);
        wr(B + 32'h000, 32'd0, 4'hF);
        for (int c = 0; c < 4; c++) wr(B + 32'h100 + 32'(8 * c), 32'(c + 1), 4'hF);
        rd(B + 32'h004, 32'h0000_000F, "rr_all_pending");
        wr(B + 32'h000, 32'd1, 4'hF);
        rd(B + 32'h004, 32'h0001_000E, "rr_status_a");
        rd(B + 32'h004, 32'h0006_0008, "rr_status_b");
        check("rr_busy_0", {31'd0, busy}, 32'd1);
        cyc1();
        check("rr_busy_1", {31'd0, busy}, 32'd1);
        cyc1();
        check("rr_busy_drop", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 4; c++) rd(B + 32'h104 + 32'(8 * c), 32'(c + 1), "rr_res");
        rd(B + 32'h008, 32'h0000_000F, "rr_done");

        // Single job with exact pipeline latency, then interrupt
        wr(B + 32'h008, 32'h0000_000F, 4'hF);
        rd(B + 32'h008, 32'h0, "w1c_all");
        wr(B + 32'h010, 32'd5, 4'hF);
        wr(B + 32'h110, 32'h10, 4'hF);
        check("job_busy_t0", {31'd0, busy}, 32'd1);
        cyc1();
        check("job_busy_t1", {31'd0, busy}, 32'd1);
        cyc1();
        check("job_busy_t2", {31'd0, busy}, 32'd1);
        cyc1();
        check("job_busy_t3", {31'd0, busy}, 32'd0);
        rd(B + 32'h114, 32'h15, "job_res2");
        rd(B + 32'h008, 32'h4, "job_done");
        rd(B + 32'h004, 32'h0, "job_status");
        wr(B + 32'h00C, 32'h4, 4'hF);
        wr(B + 32'h000, 32'h3, 4'hF);
        check("irq_reg_delay", {31'd0, irq}, 32'd0);
        cyc1();
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(B + 32'h008, 32'h4, 4'hF);
        check("irq_hold", {31'd0, irq}, 32'd1);
        cyc1();
        check("irq_clear", {31'd0, irq}, 32'd0);
        wr(B + 32'h000, 32'h1, 4'hF);

        // Byte enables and wrap-around
        wr(B + 32'h010, 32'hFFFF_FFFF, 4'hF);
        wr(B + 32'h108, 32'h0, 4'hF);
        wr(B + 32'h108, 32'hAABB_CCDD, 4'b0101);
        repeat (8) cyc1();
        rd(B + 32'h108, 32'h00BB_00DD, "be_in1");
`ifdef GONSO_SATURATE_EN
        rd(B + 32'h10C, 32'hFFFF_FFFF, "be_res1");
`else
        rd(B + 32'h10C, 32'h00BB_00DC, "be_res1");
`endif
        wr(B + 32'h010, 32'd2, 4'hF);
        wr(B + 32'h100, 32'hFFFF_FFFF, 4'hF);
        repeat (8) cyc1();
`ifdef GONSO_SATURATE_EN
        rd(B + 32'h104, 32'hFFFF_FFFF, "wrap_res0");
`else
        rd(B + 32'h104, 32'h0000_0001, "wrap_res0");
`endif

        // DONE set/clear collision: W1C lands on the writeback edge
        wr(B + 32'h008, 32'h0000_000F, 4'hF);
        rd(B + 32'h008, 32'h0, "coll_pre");
        wr(B + 32'h100, 32'd7, 4'hF);
        @(posedge clk);
        @(posedge clk);
        wr(B + 32'h008, 32'h1, 4'hF);
        rd(B + 32'h008, 32'h1, "coll_set_wins");
        rd(B + 32'h104, 32'd9, "coll_res0");
        wr(B + 32'h008, 32'h1, 4'hF);
        rd(B + 32'h008, 32'h0, "coll_w1c");

        // Unmapped / out-of-window / read-only accesses
        rd(B + 32'h800, 32'h0, "unmapped_rd");
        rd(32'h3004_0000, 32'h0, "oow_rd");
        wr(32'h3004_0000, 32'h0, 4'hF);
        rd(B + 32'h000, 32'h1, "oow_wr_ignored");
        wr(B + 32'h104, 32'hDEAD_BEEF, 4'hF);
        rd(B + 32'h104, 32'd9, "res_ro");

        // Reset with 3 jobs pending and 1 in flight
        wr(B + 32'h000, 32'h0, 4'hF);
        for (int c = 0; c < 4; c++) wr(B + 32'h100 + 32'(8 * c), 32'(c + 1), 4'hF);
        wr(B + 32'h000, 32'h1, 4'hF);
        cyc1();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cyc1();
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        rd(B + 32'h004, 32'h0, "mid_rst_status");
        rd(B + 32'h008, 32'h0, "mid_rst_done");
        rd(B + 32'h000, 32'h0, "mid_rst_ctrl");
        for (int c = 0; c < 4; c++) rd(B + 32'h104 + 32'(8 * c), 32'h0, "mid_rst_res");

        repeat (4) cyc1();
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gonso_multi_regbank.md
Name: gonso_multi_regbank

Overview:
- Wishbone-slave register bank for the Caravel user area with NCH compute channels.
- Each channel has a writable input register. A write queues a job.
- A shared LAT-stage pipeline computes result = input + step and writes it back to a read-only result register.
- On completion it sets a sticky done flag and a maskable interrupt. This block succeeds the single-channel gonso register block.

Parameters:
- NCH, 4, number of channels (1..16).
- DW, 32, data width of input/step/result (8..32); bits above DW read 0.
- LAT, 2, compute pipeline depth in cycles (1..8).
- BASE_ADDR, 32'h3003_0000, bank base; decode compares adr[31:12] with BASE_ADDR[31:12].

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_adr_i  in  32  byte address
- wbs_we_i  in  1  1 = write
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte enables
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  acknowledge
- irq  out  1  level interrupt
- busy  out  1  any job pending or in flight

Behaviour:
- Reset: all outputs 0; all registers, pending, done and pipeline-valid bits cleared.
- Bus handshake:
  - valid = cyc & stb.
  - On valid & !ack: perform access, then ack=1 the next cycle for exactly one cycle.
  - ack=0 the cycle after. Back-to-back requests get one ack every 2 cycles.
  - Any access, mapped or not, is acked; unmapped/out-of-window reads return 0 and writes are ignored.
- Writes apply per-byte via wbs_sel_i. wbs_dat_o is registered with ack.
- Register map (offsets):
  - 0x00 CTRL RW: bit0 enable, bit1 irq_en.
  - 0x04 STATUS RO: [NCH-1:0] pending, [16+NCH-1:16] in-flight.
  - 0x08 DONE: W1C, [NCH-1:0].
  - 0x0C IRQ_MASK RW: [NCH-1:0].
  - 0x10 STEP RW: DW bits.
  - 0x100+8*c IN[c] RW.
  - 0x104+8*c RES[c] RO; writes ignored.
- Job queueing:
  - Any write to IN[c] with nonzero sel sets pending[c], including a write while c is pending or in flight.
  - A write while pending updates the value; the job uses the value at issue time.
- Arbiter (per cycle):
  - If enable and pending is nonzero, grant one channel round-robin starting after the last granted channel.
  - Push {c, IN[c]+STEP} into stage 0 and clear pending[c].
  - A same-cycle write to IN[c] re-sets pending; set wins over clear.
  - One issue per cycle max.
- Pipeline:
  - LAT registered stages carrying valid, tag, data; the pipeline never stalls.
  - A job issued in cycle t writes RES[tag] and sets done[tag] in cycle t+LAT.
  - It is visible on a read requested in cycle t+LAT+1.
- Arithmetic: sum is DW-bit modulo 2^DW (wrap), e.g. 0xFFFFFFFF+2 = 0x00000001.
- DONE register:
  - Sticky; cleared by W1C.
  - Writeback set and W1C clear of the same bit in the same cycle: set wins.
- irq = irq_en & |(done & IRQ_MASK), registered (one cycle after the condition).
- busy = |pending | any stage valid.
- Clearing enable stops new issues; in-flight jobs still complete; pending is retained.
- Reset mid-operation discards all pending and in-flight jobs.

Optional Feature:
- Macro GONSO_SATURATE_EN.
- Defined: sum saturates at 2^DW-1, and STATUS bit 31 is a sticky overflow flag, set when any issued sum saturated and cleared by writing 1 to STATUS bit 31.
- Undefined: sum wraps; STATUS bit 31 reads 0.

Decomposition:
- Package gonso_pkg: register offset localparams, CTRL bit indices, and the IN/RES stride constant (8).
- Sub-module gonso_pipe (parameters LAT, DW, TW):
  - Shifts {valid, tag, data} through LAT stages.
  - Outputs wb_valid, wb_tag, wb_data.
  - Contains the wrap/saturate adder at its input.

Test Plan:
- Reset and register defaults: after reset, read CTRL, STATUS, DONE and RES[0..3] -> all 0x00000000; irq=0, busy=0.
- Single job:
  - Stimulus: enable=1, STEP=5, write IN[2]=0x10.
  - Response: RES[2]=0x15 and DONE=0x4 exactly LAT cycles after issue.
  - Then with irq_en=1 and IRQ_MASK=0x4 -> irq=1. Write DONE=0x4 -> irq=0 the next cycle.
- Round-robin ordering:
  - Stimulus: enable=0, write IN[0..3]=1,2,3,4, then enable=1.
  - Response: issues in order 0,1,2,3 on consecutive cycles; STEP=0 gives RES=1,2,3,4; busy drops LAT cycles after the last issue.
- Byte enables and wrap: write IN[1]=0xAABBCCDD with sel=0b0101 over 0 -> IN[1]=0x00BB00DD; STEP=0xFFFFFFFF -> RES[1]=0x00BB00DC (0xFFFFFFFF+1 -> 0 without GONSO_SATURATE_EN).
- Set/clear collision: W1C DONE[0] in the same cycle as the channel-0 writeback -> DONE[0] stays 1; an unmapped read at 0x3003_0800 -> ack with data 0.
- Reset mid-operation: assert rst_n low with 3 jobs pending and 1 in flight -> after release, STATUS=0, DONE=0, and no writeback occurs.
